exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception arbiter and flush controller at the MEM/WB boundary, feeding `cp0_reg`:

- Collects per-stage exception flags carried with the instruction now in MEM.
- Evaluates pending interrupts against up-to-date Status/Cause, using forwarding from a same-cycle WB `mtc0`.
- Selects one exception by MIPS priority and kills the MEM instruction's writeback.
- Drives the registered exception code, PC/address/delay-slot info that `cp0_reg` commits, and the pipeline flush / redirect PC.

## Interface
Parameters:
- FLUSH_CYCLES, 1: number of cycles `flush_o` stays high per accepted exception (1..15).

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ext_int_i  in  6  external hardware interrupt lines
- int_o  out  6  interrupt lines to `cp0_reg` `int_i`
- inst_valid_i  in  1  MEM holds a real instruction (not a bubble)
- mem_stall_i  in  1  MEM stage stalled (cache miss); no exception accepted while high
- inst_addr_i  in  32  PC of the MEM instruction
- mem_addr_i  in  32  data address of the MEM load/store
- in_delayslot_i  in  1  MEM instruction is in a delay slot
- if_adel_i, id_ri_i, id_sys_i, id_break_i, id_eret_i, ex_ov_i, mem_adel_i, mem_ades_i  in  1 each  exception flags carried with the MEM instruction
- status_i, cause_i, epc_i, ebase_i  in  32 each  current CP0 values
- wb_cp0_wen_i  in  1  WB `mtc0` write enable
- wb_cp0_waddr_i  in  5  WB `mtc0` register address
- wb_cp0_data_i  in  32  WB `mtc0` data
- mem_kill_o  out  1  combinational; suppress the MEM instruction's register/memory write this cycle
- exception_type_o  out  32  registered exception code to `cp0_reg`
- exc_inst_addr_o  out  32  registered, to `cp0_reg` `current_inst_addr_i`
- exc_mem_addr_o  out  32  registered, to `cp0_reg` `mem_data_addr_i`
- exc_delayslot_o  out  1  registered, to `cp0_reg` `is_in_delayslot_i`
- flush_o  out  1  flush IF..MEM
- new_pc_o  out  32  redirect PC, valid while `flush_o`=1

## Operation
- **Forwarding.** Effective Status/Cause/EPC/EBase = WB data when `wb_cp0_wen_i` and `wb_cp0_waddr_i` match (12/13/14/15), else the `*_i` value.
  - Cause forwarding covers bits 9:8 only.
  - EBase forward applies to address 15 only.
- **Interrupt pending.** Requires all of:
  - `(cause[15:8] & status[15:8]) != 0`
  - `status[0]`=1
  - `status[1]`=0
  - `inst_valid_i`=1
- **Priority and codes.** Highest first:
  - INT 0x1
  - if_adel 0x4
  - id_ri 0xa
  - id_sys 0x8
  - id_break 0x9
  - ex_ov 0xc
  - mem_adel 0x4
  - mem_ades 0x5
  - eret 0xe
  - Flags are ignored when `inst_valid_i`=0.
- **Detect.** `detect` = any selected code in state IDLE.
  - `mem_kill_o` = `detect`, regardless of `mem_stall_i`.
- **State machine:** IDLE, FLUSH.
  - IDLE→FLUSH on `detect & ~mem_stall_i` (accept).
  - On accept, capture:
    - `exception_type_o` = code
    - `exc_inst_addr_o` = `inst_addr_i`
    - `exc_mem_addr_o` = `mem_addr_i`
    - `exc_delayslot_o` = `in_delayslot_i`
    - `new_pc_o` = effective EPC for ERET, else effective EBase
    - `flush_o` = 1
    - counter = FLUSH_CYCLES-1
  - FLUSH: `exception_type_o`/addr/delayslot return to 0 after one cycle, so `cp0_reg` commits exactly once.
    - Counter decrements each cycle; at 0 → IDLE with `flush_o`=0.
    - Flags and `mem_stall_i` are ignored in FLUSH.
- **Stall.** `detect` with `mem_stall_i`=1 holds in IDLE. Nothing is captured until the stall drops; the exception is then accepted from the live inputs.

## Timing
- Reset (`resetn`=0 at posedge): state IDLE; counter 0; `flush_o`, `exception_type_o`, `exc_*`, `new_pc_o`, `int_o` all 0. Reset during FLUSH aborts the flush.
- Accept in cycle T:
  - `mem_kill_o`=1 in T.
  - `exception_type_o` valid for T+1 only; `cp0_reg` commits at the end of T+1.
  - `flush_o`/`new_pc_o` valid for T+1..T+FLUSH_CYCLES.
  - Earliest next accept is cycle T+FLUSH_CYCLES+1.
- `mem_kill_o` is combinational from the inputs and state.
- `int_o` latency: see Configuration.

## Configuration
- **`EXC_INT_SYNC_EN` defined:** `ext_int_i` passes through a two-flop synchronizer (reset 0) before `int_o`.
  - 2-cycle latency.
  - Interrupt pending reflects Cause as updated by `cp0_reg` from the synced lines.
- **Undefined:** `int_o` = `ext_int_i` combinationally, 0 latency.

## Test plan
- Reset, then `id_sys_i`=1, `inst_addr_i`=0xBFC00100, valid, no stall → `mem_kill_o`=1 in T; T+1: `exception_type_o`=0x8, `exc_inst_addr_o`=0xBFC00100, `new_pc_o`=`ebase_i`, `flush_o`=1; T+2: `exception_type_o`=0.
- `id_eret_i`=1 with `epc_i`=0x80001000, WB `mtc0` to reg 14 data 0x80002000 in the same cycle → `new_pc_o`=0x80002000, code 0xe.
- `ex_ov_i` and `mem_ades_i` both set, plus an interrupt pending (status=0x0000_0401, cause[10]=1) → code 0x1; repeat with status[1]=1 → code 0xc.
- `mem_adel_i`=1 with `mem_stall_i`=1 for 3 cycles → `mem_kill_o`=1 throughout, `flush_o`=0; stall drops → next cycle code 0x4, `exc_mem_addr_o` = `mem_addr_i`.
- FLUSH_CYCLES=3: accept, then `id_ri_i`=1 during FLUSH → ignored, `flush_o` high exactly 3 cycles; assert reset mid-flush → `flush_o`=0 next cycle.
- `ext_int_i`=6'b000100 → `int_o` follows after 2 cycles with `EXC_INT_SYNC_EN`, 0 cycles without.

Source files
------------

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exc_ctrl
// Description : MEM/WB exception arbiter and flush controller feeding cp0_reg.
//               Optional macro EXC_INT_SYNC_EN adds a 2-flop ext_int_i sync.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  ext_int_i,
    output logic [5:0]  int_o,
    input  logic        inst_valid_i,
    input  logic        mem_stall_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] mem_addr_i,
    input  logic        in_delayslot_i,
    input  logic        if_adel_i,
    input  logic        id_ri_i,
    input  logic        id_sys_i,
    input  logic        id_break_i,
    input  logic        id_eret_i,
    input  logic        ex_ov_i,
    input  logic        mem_adel_i,
    input  logic        mem_ades_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic        wb_cp0_wen_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic        mem_kill_o,
    output logic [31:0] exception_type_o,
    output logic [31:0] exc_inst_addr_o,
    output logic [31:0] exc_mem_addr_o,
    output logic        exc_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [31:0] C_CODE_NONE  = 32'h0;
    localparam logic [31:0] C_CODE_INT   = 32'h1;
    localparam logic [31:0] C_CODE_ADEL  = 32'h4;
    localparam logic [31:0] C_CODE_ADES  = 32'h5;
    localparam logic [31:0] C_CODE_SYS   = 32'h8;
    localparam logic [31:0] C_CODE_BREAK = 32'h9;
    localparam logic [31:0] C_CODE_RI    = 32'ha;
    localparam logic [31:0] C_CODE_OV    = 32'hc;
    localparam logic [31:0] C_CODE_ERET  = 32'he;
    localparam logic [3:0]  C_CNT_INIT   = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_type, w_type_nxt;
    logic [31:0] r_inst_addr, w_inst_addr_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic        r_delayslot, w_delayslot_nxt;
    logic        r_flush, w_flush_nxt;
    logic [31:0] r_new_pc, w_new_pc_nxt;

    logic [31:0] w_status;
    logic [7:0]  w_cause_ip;
    logic [31:0] w_epc;
    logic [31:0] w_ebase;
    logic        w_int_pend;
    logic [31:0] w_code;
    logic        w_detect;
    logic        w_unused;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] r_int_meta;
    logic [5:0] r_int_sync;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_int_meta <= 6'd0;
            r_int_sync <= 6'd0;
        end else begin
            r_int_meta <= ext_int_i;
            r_int_sync <= r_int_meta;
        end
    end

    assign int_o = r_int_sync;
`else
    assign int_o = ext_int_i;
`endif

    // A WB mtc0 in the same cycle has not reached cp0_reg yet; forward it.
    assign w_status   = (wb_cp0_wen_i && wb_cp0_waddr_i == 5'd12) ? wb_cp0_data_i : status_i;
    assign w_cause_ip = {cause_i[15:10],
                         (wb_cp0_wen_i && wb_cp0_waddr_i == 5'd13) ? wb_cp0_data_i[9:8] : cause_i[9:8]};
    assign w_epc      = (wb_cp0_wen_i && wb_cp0_waddr_i == 5'd14) ? wb_cp0_data_i : epc_i;
    assign w_ebase    = (wb_cp0_wen_i && wb_cp0_waddr_i == 5'd15) ? wb_cp0_data_i : ebase_i;

    assign w_int_pend = (|(w_cause_ip & w_status[15:8])) & w_status[0] & ~w_status[1] & inst_valid_i;

    always_comb begin
        w_code = C_CODE_NONE;
        if (inst_valid_i) begin
            if (w_int_pend)      w_code = C_CODE_INT;
            else if (if_adel_i)  w_code = C_CODE_ADEL;
            else if (id_ri_i)    w_code = C_CODE_RI;
            else if (id_sys_i)   w_code = C_CODE_SYS;
            else if (id_break_i) w_code = C_CODE_BREAK;
            else if (ex_ov_i)    w_code = C_CODE_OV;
            else if (mem_adel_i) w_code = C_CODE_ADEL;
            else if (mem_ades_i) w_code = C_CODE_ADES;
            else if (id_eret_i)  w_code = C_CODE_ERET;
        end
    end

    assign w_detect   = (r_state == S_IDLE) && (w_code != C_CODE_NONE);
    assign mem_kill_o = w_detect;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_type_nxt      = C_CODE_NONE;
        w_inst_addr_nxt = 32'd0;
        w_mem_addr_nxt  = 32'd0;
        w_delayslot_nxt = 1'b0;
        w_flush_nxt     = r_flush;
        w_new_pc_nxt    = r_new_pc;
        case (r_state)
            S_IDLE: begin
                w_flush_nxt = 1'b0;
                // A stalled MEM holds the exception until the stall drops.
                if (w_detect && !mem_stall_i) begin
                    w_state_nxt     = S_FLUSH;
                    w_cnt_nxt       = C_CNT_INIT;
                    w_type_nxt      = w_code;
                    w_inst_addr_nxt = inst_addr_i;
                    w_mem_addr_nxt  = mem_addr_i;
                    w_delayslot_nxt = in_delayslot_i;
                    w_flush_nxt     = 1'b1;
                    w_new_pc_nxt    = (w_code == C_CODE_ERET) ? w_epc : w_ebase;
                end
            end
            S_FLUSH: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                    w_flush_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_type      <= C_CODE_NONE;
            r_inst_addr <= 32'd0;
            r_mem_addr  <= 32'd0;
            r_delayslot <= 1'b0;
            r_flush     <= 1'b0;
            r_new_pc    <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_type      <= w_type_nxt;
            r_inst_addr <= w_inst_addr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_delayslot <= w_delayslot_nxt;
            r_flush     <= w_flush_nxt;
            r_new_pc    <= w_new_pc_nxt;
        end
    end

    assign exception_type_o = r_type;
    assign exc_inst_addr_o  = r_inst_addr;
    assign exc_mem_addr_o   = r_mem_addr;
    assign exc_delayslot_o  = r_delayslot;
    assign flush_o          = r_flush;
    assign new_pc_o         = r_new_pc;

    assign w_unused = ^{1'b0, cause_i[31:16], cause_i[7:0]};

endmodule
`default_nettype wire

// File: tb/tb_exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_ctrl
// Description : Randomized self-checking bench for exc_ctrl (FLUSH_CYCLES 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  ext_int_i;
    logic        inst_valid_i, mem_stall_i, in_delayslot_i;
    logic [31:0] inst_addr_i, mem_addr_i;
    logic        if_adel_i, id_ri_i, id_sys_i, id_break_i, id_eret_i, ex_ov_i, mem_adel_i, mem_ades_i;
    logic [31:0] status_i, cause_i, epc_i, ebase_i;
    logic        wb_cp0_wen_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_data_i;

    logic [5:0]  int_w   [2];
    logic        kill_w  [2];
    logic [31:0] type_w  [2];
    logic [31:0] ia_w    [2];
    logic [31:0] ma_w    [2];
    logic        ds_w    [2];
    logic        flush_w [2];
    logic [31:0] pc_w    [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .resetn(resetn), .ext_int_i(ext_int_i), .int_o(int_w[0]),
        .inst_valid_i(inst_valid_i), .mem_stall_i(mem_stall_i), .inst_addr_i(inst_addr_i),
        .mem_addr_i(mem_addr_i), .in_delayslot_i(in_delayslot_i), .if_adel_i(if_adel_i),
        .id_ri_i(id_ri_i), .id_sys_i(id_sys_i), .id_break_i(id_break_i), .id_eret_i(id_eret_i),
        .ex_ov_i(ex_ov_i), .mem_adel_i(mem_adel_i), .mem_ades_i(mem_ades_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .ebase_i(ebase_i),
        .wb_cp0_wen_i(wb_cp0_wen_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .mem_kill_o(kill_w[0]), .exception_type_o(type_w[0]), .exc_inst_addr_o(ia_w[0]),
        .exc_mem_addr_o(ma_w[0]), .exc_delayslot_o(ds_w[0]), .flush_o(flush_w[0]), .new_pc_o(pc_w[0])
    );

    exc_ctrl #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .resetn(resetn), .ext_int_i(ext_int_i), .int_o(int_w[1]),
        .inst_valid_i(inst_valid_i), .mem_stall_i(mem_stall_i), .inst_addr_i(inst_addr_i),
        .mem_addr_i(mem_addr_i), .in_delayslot_i(in_delayslot_i), .if_adel_i(if_adel_i),
        .id_ri_i(id_ri_i), .id_sys_i(id_sys_i), .id_break_i(id_break_i), .id_eret_i(id_eret_i),
        .ex_ov_i(ex_ov_i), .mem_adel_i(mem_adel_i), .mem_ades_i(mem_ades_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .ebase_i(ebase_i),
        .wb_cp0_wen_i(wb_cp0_wen_i), .wb_cp0_waddr_i(wb_cp0_waddr_i), .wb_cp0_data_i(wb_cp0_data_i),
        .mem_kill_o(kill_w[1]), .exception_type_o(type_w[1]), .exc_inst_addr_o(ia_w[1]),
        .exc_mem_addr_o(ma_w[1]), .exc_delayslot_o(ds_w[1]), .flush_o(flush_w[1]), .new_pc_o(pc_w[1])
    );

    // Reference model: per instance, cycles of flush left and the expected registered outputs.
    int          m_fc    [2] = '{1, 3};
    int          m_busy  [2];
    logic [31:0] m_type  [2];
    logic [31:0] m_ia    [2];
    logic [31:0] m_ma    [2];
    logic        m_ds    [2];
    logic        m_flush [2];
    logic [31:0] m_pc    [2];
    logic        m_pc_chk;
    logic [5:0]  m_ext_d1;
    logic        m_rst_d1;
    logic [5:0]  m_int_exp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] eff(input logic [4:0] addr, input logic [31:0] base);
        return (wb_cp0_wen_i && wb_cp0_waddr_i == addr) ? wb_cp0_data_i : base;
    endfunction

    function automatic logic [31:0] model_code();
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] codes [8];
        logic        flags [8];
        st = eff(5'd12, status_i);
        ca = cause_i;
        if (wb_cp0_wen_i && wb_cp0_waddr_i == 5'd13) ca[9:8] = wb_cp0_data_i[9:8];
        if (!inst_valid_i) return 32'h0;
        if ((ca[15:8] & st[15:8]) != 8'h0 && st[0] && !st[1]) return 32'h1;
        flags = '{if_adel_i, id_ri_i, id_sys_i, id_break_i, ex_ov_i, mem_adel_i, mem_ades_i, id_eret_i};
        codes = '{32'h4, 32'ha, 32'h8, 32'h9, 32'hc, 32'h4, 32'h5, 32'he};
        for (int i = 0; i < 8; i++)
            if (flags[i]) return codes[i];
        return 32'h0;
    endfunction

    task automatic model_edge(input logic [31:0] code);
        for (int k = 0; k < 2; k++) begin
            m_type[k] = 32'h0;
            m_ia[k]   = 32'h0;
            m_ma[k]   = 32'h0;
            m_ds[k]   = 1'b0;
            if (!resetn) begin
                m_busy[k]  = 0;
                m_flush[k] = 1'b0;
                m_pc[k]    = 32'h0;
            end else if (m_busy[k] > 0) begin
                m_busy[k]  = m_busy[k] - 1;
                m_flush[k] = (m_busy[k] > 0);
            end else if (code != 32'h0 && !mem_stall_i) begin
                m_busy[k]  = m_fc[k];
                m_flush[k] = 1'b1;
                m_type[k]  = code;
                m_ia[k]    = inst_addr_i;
                m_ma[k]    = mem_addr_i;
                m_ds[k]    = in_delayslot_i;
                m_pc[k]    = (code == 32'he) ? eff(5'd14, epc_i) : eff(5'd15, ebase_i);
            end else begin
                m_flush[k] = 1'b0;
            end
        end
        m_pc_chk  = !resetn;
        m_int_exp = (resetn && m_rst_d1) ? m_ext_d1 : 6'h0;
        m_ext_d1  = ext_int_i;
        m_rst_d1  = resetn;
    endtask

    task automatic cycle();
        logic [31:0] code;
        @(negedge clk);
        code = model_code();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.kill", k), {31'h0, kill_w[k]}, {31'h0, (m_busy[k] == 0 && code != 32'h0)});
`ifndef EXC_INT_SYNC_EN
            check($sformatf("d%0d.int", k), {26'h0, int_w[k]}, {26'h0, ext_int_i});
`endif
        end
        @(posedge clk);
        model_edge(code);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.type", k), type_w[k], m_type[k]);
            check($sformatf("d%0d.iaddr", k), ia_w[k], m_ia[k]);
            check($sformatf("d%0d.maddr", k), ma_w[k], m_ma[k]);
            check($sformatf("d%0d.dslot", k), {31'h0, ds_w[k]}, {31'h0, m_ds[k]});
            check($sformatf("d%0d.flush", k), {31'h0, flush_w[k]}, {31'h0, m_flush[k]});
            if (m_flush[k] || m_pc_chk)
                check($sformatf("d%0d.newpc", k), pc_w[k], m_pc[k]);
`ifdef EXC_INT_SYNC_EN
            check($sformatf("d%0d.int", k), {26'h0, int_w[k]}, {26'h0, m_int_exp});
`endif
        end
    endtask

    task automatic clear_flags();
        {if_adel_i, id_ri_i, id_sys_i, id_break_i, id_eret_i, ex_ov_i, mem_adel_i, mem_ades_i} = 8'h0;
        inst_valid_i = 1'b0;
        mem_stall_i  = 1'b0;
        wb_cp0_wen_i = 1'b0;
    endtask

    task automatic idle_n(input int n);
        clear_flags();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 0; m_flush[k] = 1'b0; m_pc[k] = 32'h0;
        end
        m_ext_d1 = 6'h0; m_rst_d1 = 1'b0; m_pc_chk = 1'b0; m_int_exp = 6'h0;
        resetn = 1'b0;
        ext_int_i = 6'h0;
        clear_flags();
        in_delayslot_i = 1'b0;
        inst_addr_i = 32'h0; mem_addr_i = 32'h0;
        status_i = 32'h0; cause_i = 32'h0; epc_i = 32'h0; ebase_i = 32'h8000_0180;
        wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
        cycle(); cycle();
        resetn = 1'b1;
        idle_n(2);

        // syscall
        inst_valid_i = 1'b1; id_sys_i = 1'b1; inst_addr_i = 32'hBFC0_0100;
        cycle();
        check("tp.sys.type", type_w[0], 32'h8);
        check("tp.sys.pc", pc_w[0], 32'h8000_0180);
        check("tp.sys.ia", ia_w[0], 32'hBFC0_0100);
        idle_n(1);
        check("tp.sys.type0", type_w[0], 32'h0);
        idle_n(3);

        // eret with same-cycle EPC forward
        inst_valid_i = 1'b1; id_eret_i = 1'b1; epc_i = 32'h8000_1000;
        wb_cp0_wen_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h8000_2000;
        cycle();
        check("tp.eret.type", type_w[0], 32'he);
        check("tp.eret.pc", pc_w[1], 32'h8000_2000);
        idle_n(4);

        // interrupt beats overflow and store address error, unless EXL set
        inst_valid_i = 1'b1; ex_ov_i = 1'b1; mem_ades_i = 1'b1;
        status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
        cycle();
        check("tp.int.type", type_w[0], 32'h1);
        idle_n(4);
        inst_valid_i = 1'b1; ex_ov_i = 1'b1; mem_ades_i = 1'b1; status_i = 32'h0000_0403;
        cycle();
        check("tp.exl.type", type_w[1], 32'hc);
        idle_n(4);
        status_i = 32'h0; cause_i = 32'h0;

        // load address error held by a stall
        inst_valid_i = 1'b1; mem_adel_i = 1'b1; mem_stall_i = 1'b1; mem_addr_i = 32'h1234_5679;
        for (int i = 0; i < 3; i++) cycle();
        check("tp.stall.flush", {31'h0, flush_w[0]}, 32'h0);
        mem_stall_i = 1'b0;
        cycle();
        check("tp.stall.type", type_w[0], 32'h4);
        check("tp.stall.ma", ma_w[0], 32'h1234_5679);
        idle_n(4);

        // flags during a flush are ignored by the 3-cycle instance
        inst_valid_i = 1'b1; id_sys_i = 1'b1;
        cycle();
        id_sys_i = 1'b0; id_ri_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        idle_n(4);

        // reset in the middle of a flush
        inst_valid_i = 1'b1; id_break_i = 1'b1;
        cycle();
        idle_n(1);
        resetn = 1'b0;
        cycle();
        check("tp.rstmid.flush", {31'h0, flush_w[1]}, 32'h0);
        resetn = 1'b1;
        idle_n(2);

        // interrupt line pass-through
        ext_int_i = 6'b000100;
        idle_n(2);
        check("tp.int_o", {26'h0, int_w[0]}, 32'h4);
        idle_n(1);

        for (int n = 0; n < 800; n++) begin
            resetn         = ($urandom_range(0, 59) != 0);
            ext_int_i      = 6'($urandom);
            inst_valid_i   = ($urandom_range(0, 4) != 0);
            mem_stall_i    = ($urandom_range(0, 3) == 0);
            in_delayslot_i = 1'($urandom);
            inst_addr_i    = $urandom;
            mem_addr_i     = $urandom;
            if_adel_i      = ($urandom_range(0, 11) == 0);
            id_ri_i        = ($urandom_range(0, 11) == 0);
            id_sys_i       = ($urandom_range(0, 11) == 0);
            id_break_i     = ($urandom_range(0, 11) == 0);
            id_eret_i      = ($urandom_range(0, 7) == 0);
            ex_ov_i        = ($urandom_range(0, 11) == 0);
            mem_adel_i     = ($urandom_range(0, 11) == 0);
            mem_ades_i     = ($urandom_range(0, 11) == 0);
            status_i       = $urandom;
            status_i[0]    = ($urandom_range(0, 3) != 0);
            status_i[1]    = ($urandom_range(0, 3) == 0);
            cause_i        = $urandom & 32'hFFFF_00FF;
            if ($urandom_range(0, 1) == 0) cause_i[15:8] = 8'h0;
            epc_i          = $urandom;
            ebase_i        = $urandom;
            wb_cp0_wen_i   = ($urandom_range(0, 2) == 0);
            wb_cp0_waddr_i = ($urandom_range(0, 4) != 0) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
            wb_cp0_data_i  = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
